// File: rtl/phy_rx_sync_deser.sv
// Serial-to-parallel receive stage: slides bit-by-bit to find the COM symbol,
// confirms byte alignment over LOCK_COUNT COMs, then emits one parallel byte per 8 clocks.
module phy_rx_sync_deser #(
  parameter logic [7:0] COM        = 8'hBC,
  parameter int         LOCK_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       active,
  output logic [1:0] sync_state
);

  typedef enum logic [1:0] {
    SEARCH  = 2'b00,
    LOCKING = 2'b01,
    ACTIVE  = 2'b10,
    UNUSED  = 2'b11
  } state_t;

  localparam logic [3:0] LOCK_TARGET = 4'(LOCK_COUNT);

  state_t     state_q, state_d;
  logic [7:0] sr_q, sr_next;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] com_cnt_q, com_cnt_d, com_cnt_inc;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       strobe_q, strobe_d;
  logic       is_com, byte_done;

  assign sr_next     = {sr_q[6:0], data_in};
  assign is_com      = (sr_next == COM);
  assign byte_done   = (bit_cnt_q == 3'd7);
  assign com_cnt_inc = com_cnt_q + 4'd1;

  // NOTE: every variable gets a default before the case so no path can leave
  // one unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q + 3'd1;
    com_cnt_d = com_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    strobe_d  = 1'b0;

    case (state_q)
      SEARCH: begin
        bit_cnt_d = 3'd0;
        valid_d   = 1'b0;
        if (is_com) begin
          state_d   = LOCKING;
          com_cnt_d = 4'd1;
        end
      end

      LOCKING: begin
        valid_d = 1'b0;
        if (byte_done) begin
          if (is_com) begin
            com_cnt_d = com_cnt_inc;
            if (com_cnt_inc == LOCK_TARGET) state_d = ACTIVE;
          end else begin
            // Misaligned byte: sliding search restarts on the next bit, not this one.
            state_d   = SEARCH;
            com_cnt_d = 4'd0;
          end
        end
      end

      ACTIVE: begin
        if (byte_done) begin
          strobe_d = 1'b1;
          if (is_com) begin
            valid_d = 1'b0;
          end else begin
            data_d  = sr_next;
            valid_d = 1'b1;
          end
        end
      end

      default: begin
        state_d   = SEARCH;
        bit_cnt_d = 3'd0;
        com_cnt_d = 4'd0;
        valid_d   = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state_q   <= SEARCH;
      sr_q      <= 8'h00;
      bit_cnt_q <= 3'd0;
      com_cnt_q <= 4'd0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_next;
      bit_cnt_q <= bit_cnt_d;
      com_cnt_q <= com_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      strobe_q  <= strobe_d;
    end
  end

  assign data_out    = data_q;
  assign valid_out   = valid_q;
  assign byte_strobe = strobe_q;
  assign active      = (state_q == ACTIVE);
  assign sync_state  = state_q;

endmodule
